// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared APU frame timing constants and mode encodings.
package apu_pkg;

  localparam int unsigned CNT_W = 15;

  localparam int unsigned STEP1_DEF = 3729;
  localparam int unsigned STEP2_DEF = 7457;
  localparam int unsigned STEP3_DEF = 11186;
  localparam int unsigned STEP4_DEF = 14915;
  localparam int unsigned STEP5_DEF = 18641;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - control strobes in, frame ticks and IRQ out.
interface frame_sequencer_if;

  logic       in_apu_en;
  logic       in_wr;
  logic [1:0] in_wr_data;
  logic       in_irq_ack;
  logic       qfr_tick;
  logic       hfr_tick;
  logic       frame_irq;

  modport master (
    output in_apu_en, in_wr, in_wr_data, in_irq_ack,
    input  qfr_tick, hfr_tick, frame_irq
  );

  modport slave (
    input  in_apu_en, in_wr, in_wr_data, in_irq_ack,
    output qfr_tick, hfr_tick, frame_irq
  );

endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - APU frame sequencer: quarter/half-frame strobes
// and the 4-step frame interrupt, driven by an APU-cycle counter.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP1 = STEP1_DEF,
  parameter int unsigned STEP2 = STEP2_DEF,
  parameter int unsigned STEP3 = STEP3_DEF,
  parameter int unsigned STEP4 = STEP4_DEF,
  parameter int unsigned STEP5 = STEP5_DEF
) (
  input logic              in_clk,
  input logic              in_rst,
  frame_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt, cnt_n;
  seq_mode_e        mode, mode_n;
  logic             inhibit, inhibit_n;
  logic             qfr_q, qfr_n;
  logic             hfr_q, hfr_n;
  logic             irq_q, irq_n;
  logic             hit_qtr, hit_half, hit_end;

  always_comb begin
    cnt_n     = cnt;
    mode_n    = mode;
    inhibit_n = inhibit;
    qfr_n     = 1'b0;
    hfr_n     = 1'b0;
    irq_n     = irq_q;

    hit_qtr  = bus.in_apu_en && (cnt == S1 || cnt == S3);
    hit_half = bus.in_apu_en && (cnt == S2);
    hit_end  = bus.in_apu_en &&
               ((mode == MODE_4STEP && cnt == S4) ||
                (mode == MODE_5STEP && cnt == S5));

    if (bus.in_irq_ack)
      irq_n = 1'b0;

    // A register write overrides any step match on the same cycle.
    if (bus.in_wr) begin
      cnt_n     = '0;
      mode_n    = seq_mode_e'(bus.in_wr_data[1]);
      inhibit_n = bus.in_wr_data[0];
      qfr_n     = bus.in_wr_data[1];
      hfr_n     = bus.in_wr_data[1];
      if (bus.in_wr_data[0])
        irq_n = 1'b0;
    end else begin
      cnt_n = hit_end ? '0 : cnt + {{(CNT_W-1){1'b0}}, bus.in_apu_en};
      qfr_n = hit_qtr | hit_half | hit_end;
      hfr_n = hit_half | hit_end;
      // Setting after the ack clear lets a coincident set win.
      if (hit_end && mode == MODE_4STEP && !inhibit)
        irq_n = 1'b1;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt     <= '0;
      mode    <= MODE_4STEP;
      inhibit <= 1'b0;
      qfr_q   <= 1'b0;
      hfr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      mode    <= mode_n;
      inhibit <= inhibit_n;
      qfr_q   <= qfr_n;
      hfr_q   <= hfr_n;
      irq_q   <= irq_n;
    end
  end

  assign bus.qfr_tick  = qfr_q;
  assign bus.hfr_tick  = hfr_q;
  assign bus.frame_irq = irq_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer.
module tb_frame_sequencer;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;

  frame_sequencer_if bus ();

  frame_sequencer dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int clk_cnt = 0;
  int apu_cnt = 0;
  int irq_rise_at = -1;
  int start_clk;
  int qfr_at[$];
  int hfr_at[$];
  int qfr_clk[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic cyc();
    @(posedge in_clk);
    #1;
    clk_cnt++;
  endtask

  task automatic clear_log();
    qfr_at.delete();
    hfr_at.delete();
    qfr_clk.delete();
    irq_rise_at = -1;
  endtask

  // idx is the APU cycle count the DUT counter held when the strobe was caused.
  task automatic note(input int idx);
    if (bus.qfr_tick) begin
      qfr_at.push_back(idx);
      qfr_clk.push_back(clk_cnt);
    end
    if (bus.hfr_tick) hfr_at.push_back(idx);
    if (bus.frame_irq && irq_rise_at < 0) irq_rise_at = idx;
  endtask

  task automatic apu_run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_apu_en = 1'b0;
        cyc();
        note(-1);
      end
      bus.in_apu_en = 1'b1;
      cyc();
      note(apu_cnt);
      apu_cnt++;
    end
    bus.in_apu_en = 1'b0;
  endtask

  task automatic write_ctrl(input logic [1:0] data, input logic en);
    bus.in_wr      = 1'b1;
    bus.in_wr_data = data;
    bus.in_apu_en  = en;
    cyc();
    bus.in_wr      = 1'b0;
    bus.in_apu_en  = 1'b0;
    apu_cnt        = 0;
  endtask

  initial begin
    bus.in_apu_en  = 1'b0;
    bus.in_wr      = 1'b0;
    bus.in_wr_data = 2'b00;
    bus.in_irq_ack = 1'b0;
    repeat (3) cyc();
    check("rst_qfr", int'(bus.qfr_tick), 0);
    check("rst_hfr", int'(bus.hfr_tick), 0);
    check("rst_irq", int'(bus.frame_irq), 0);
    #2 in_rst = 1'b0;

    // 4-step frame, enable every clock
    clear_log();
    apu_run(14916, 0);
    apu_cnt = 0;
    check("m0_qfr_n", qfr_at.size(), 4);
    check("m0_qfr0", at(qfr_at, 0), 3729);
    check("m0_qfr1", at(qfr_at, 1), 7457);
    check("m0_qfr2", at(qfr_at, 2), 11186);
    check("m0_qfr3", at(qfr_at, 3), 14915);
    check("m0_hfr_n", hfr_at.size(), 2);
    check("m0_hfr0", at(hfr_at, 0), 7457);
    check("m0_hfr1", at(hfr_at, 1), 14915);
    check("m0_irq_rise", irq_rise_at, 14915);
    check("m0_irq", int'(bus.frame_irq), 1);

    // ack clears, then ack coincident with the set
    bus.in_irq_ack = 1'b1;
    cyc();
    bus.in_irq_ack = 1'b0;
    check("ack_clr", int'(bus.frame_irq), 0);
    clear_log();
    apu_run(14915, 0);
    check("ack_run_qfr_n", qfr_at.size(), 3);
    check("ack_run_irq", irq_rise_at, -1);
    bus.in_irq_ack = 1'b1;
    bus.in_apu_en  = 1'b1;
    cyc();
    bus.in_irq_ack = 1'b0;
    bus.in_apu_en  = 1'b0;
    apu_cnt = 0;
    check("ack_vs_set_irq", int'(bus.frame_irq), 1);
    check("ack_vs_set_qfr", int'(bus.qfr_tick), 1);
    check("ack_vs_set_hfr", int'(bus.hfr_tick), 1);

    // inhibit write clears IRQ and keeps it clear for a full frame
    write_ctrl(2'b01, 1'b0);
    check("inh_irq_clr", int'(bus.frame_irq), 0);
    check("inh_no_imm", int'(bus.qfr_tick), 0);
    clear_log();
    apu_run(14916, 0);
    apu_cnt = 0;
    check("inh_qfr_n", qfr_at.size(), 4);
    check("inh_qfr3", at(qfr_at, 3), 14915);
    check("inh_hfr_n", hfr_at.size(), 2);
    check("inh_irq_rise", irq_rise_at, -1);

    // 5-step mode with immediate clock
    write_ctrl(2'b10, 1'b0);
    check("m1_imm_qfr", int'(bus.qfr_tick), 1);
    check("m1_imm_hfr", int'(bus.hfr_tick), 1);
    clear_log();
    apu_run(18642, 0);
    apu_cnt = 0;
    check("m1_qfr_n", qfr_at.size(), 4);
    check("m1_qfr0", at(qfr_at, 0), 3729);
    check("m1_qfr1", at(qfr_at, 1), 7457);
    check("m1_qfr2", at(qfr_at, 2), 11186);
    check("m1_qfr3", at(qfr_at, 3), 18641);
    check("m1_hfr_n", hfr_at.size(), 2);
    check("m1_hfr1", at(hfr_at, 1), 18641);
    check("m1_irq_rise", irq_rise_at, -1);

    // write on a step-match cycle suppresses the step tick
    clear_log();
    apu_run(3729, 0);
    check("wr_step_pre", qfr_at.size(), 0);
    write_ctrl(2'b00, 1'b1);
    check("wr_step_qfr", int'(bus.qfr_tick), 0);
    check("wr_step_hfr", int'(bus.hfr_tick), 0);

    // 1-in-2 enable duty
    clear_log();
    start_clk = clk_cnt;
    apu_run(3730, 1);
    check("duty_qfr_n", qfr_at.size(), 1);
    check("duty_qfr0", at(qfr_at, 0), 3729);
    check("duty_clks", at(qfr_clk, 0) - start_clk, 7460);

    // async reset while a strobe is high
    check("async_pre_qfr", int'(bus.qfr_tick), 1);
    #1 in_rst = 1'b1;
    #1 check("async_qfr", int'(bus.qfr_tick), 0);
    #1 in_rst = 1'b0;
    apu_cnt = 0;

    // reset mid-frame at counter 5000
    apu_run(5000, 0);
    #1 in_rst = 1'b1;
    #1;
    check("rst5k_qfr", int'(bus.qfr_tick), 0);
    check("rst5k_hfr", int'(bus.hfr_tick), 0);
    check("rst5k_irq", int'(bus.frame_irq), 0);
    cyc();
    #2 in_rst = 1'b0;
    apu_cnt = 0;
    clear_log();
    apu_run(3730, 0);
    check("rst5k_qfr_n", qfr_at.size(), 1);
    check("rst5k_qfr0", at(qfr_at, 0), 3729);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
